fetch_unit: RTL and testbench

- Instruction-fetch stage. Owns the PC register and issues single-outstanding requests to instruction memory.
- Presents {pc, instr} to decode with a valid/ready handshake.
- Consumes the jump/branch redirect (target address + take flag) produced by the execute stage.
- Sits directly upstream of decode; closes the PC loop with execute.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/add_pg_32.sv | 25 ++
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
    localparam int unsigned PC_STEP_DEFAULT = 4;

endpackage

// File: rtl/add_pg_32.sv
// 32-bit generate/propagate ripple adder; the sum wraps, no carry out.
module add_pg_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum
);

    logic [30:0] g;
    logic [31:0] p;
    logic [31:0] c;

    assign g = a[30:0] & b[30:0];
    assign p = a ^ b;

    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int i = 1; i < 32; i++) begin
            c[i] = g[i-1] | (p[i-1] & c[i-1]);
        end
        sum = p ^ c;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding imem requests, one-deep decode buffer.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    input  logic        i_jump_sel,
    input  logic [31:0] i_jump_addr
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        o_misaligned
`endif
);

    localparam logic [31:0] PC_STEP_W = 32'(PC_STEP);

    fetch_state_e state, state_nxt;
    logic         drop, drop_nxt;
    logic         halt;
    logic         gnt_acc;
    logic         rsp_acc;
    logic [31:0]  pc;
    logic [31:0]  pc_req;
    logic [31:0]  pc_inc;

`ifdef FETCH_MISALIGN_TRAP_EN
    // Sticky trap: a redirect to a halfword address stops fetch until reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_misaligned <= 1'b0;
        end else if (i_jump_sel && i_jump_addr[1]) begin
            o_misaligned <= 1'b1;
        end
    end

    assign halt = o_misaligned;
`else
    assign halt = 1'b0;
`endif

    assign gnt_acc = (state == ST_REQ) && !halt && i_imem_gnt;
    assign rsp_acc = (state == ST_WAIT) && i_imem_rvalid && !drop && !i_jump_sel;

    add_pg_32 u_pc_inc (
        .a   (pc_req),
        .b   (PC_STEP_W),
        .cin (1'b0),
        .sum (pc_inc)
    );

    // A reset that lands in WAIT leaves one response in flight; mark it for discard.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_REQ;
            drop  <= (state == ST_WAIT);
        end else begin
            state <= state_nxt;
            drop  <= drop_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        drop_nxt  = drop;
        case (state)
            ST_REQ: begin
                if (gnt_acc) begin
                    state_nxt = ST_WAIT;
                    drop_nxt  = drop | i_jump_sel;
                end
            end
            ST_WAIT: begin
                if (i_imem_rvalid) begin
                    drop_nxt  = 1'b0;
                    state_nxt = (drop || i_jump_sel) ? ST_REQ : ST_HOLD;
                end else if (i_jump_sel) begin
                    drop_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                if (i_jump_sel || i_ready) begin
                    state_nxt = ST_REQ;
                end
            end
            default: begin
                state_nxt = ST_REQ;
            end
        endcase
    end

    always_comb begin
        o_imem_req = (state == ST_REQ) && !halt && !i_rst;
        o_valid    = (state == ST_HOLD);
    end

    assign o_imem_addr = pc;

    // Redirect is written last so it overrides the sequential increment.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc      <= RESET_PC;
            o_instr <= NOP_INSTR;
            o_pc    <= RESET_PC;
        end else begin
            if (gnt_acc) begin
                pc_req <= pc;
            end
            if (rsp_acc) begin
                o_instr <= i_imem_rdata;
                o_pc    <= pc_req;
                pc      <= pc_inc;
            end
            if (i_jump_sel) begin
                pc <= i_jump_addr & ~32'h3;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-outstanding instruction-memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt = 1'b1;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = '0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        i_jump_sel = 1'b0;
    logic [31:0] i_jump_addr = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        o_misaligned;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 1;

    logic [31:0] xfer_pc[$];
    logic [31:0] xfer_instr[$];
    logic [31:0] req_addr[$];

    logic        m_busy = 1'b0;
    int          m_cnt  = 0;
    logic [31:0] m_addr = '0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .i_jump_sel    (i_jump_sel),
        .i_jump_addr   (i_jump_addr)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .o_misaligned  (o_misaligned)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory: grant decided just before the edge, response lat cycles after the grant.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            i_imem_rvalid = 1'b0;
            if (m_busy) begin
                if (m_cnt == 0) begin
                    i_imem_rvalid = 1'b1;
                    i_imem_rdata  = mem_word(m_addr);
                    m_busy        = 1'b0;
                end else begin
                    m_cnt--;
                end
            end
            if (o_imem_req && i_imem_gnt) begin
                m_busy = 1'b1;
                m_addr = o_imem_addr;
                m_cnt  = lat - 1;
                req_addr.push_back(o_imem_addr);
            end
        end
    end

    // Decode side: record every transfer that is not flushed by a redirect.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (o_valid && i_ready && !i_jump_sel) begin
                xfer_pc.push_back(o_pc);
                xfer_instr.push_back(o_instr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_q();
        xfer_pc.delete();
        xfer_instr.delete();
        req_addr.delete();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        i_jump_sel = 1'b0;
        tick(3);
        clear_q();
        rst = 1'b0;
    endtask

    task automatic wait_xfers(input string tag, input int n, input int budget);
        int c = 0;
        while (xfer_pc.size() < n && c < budget) begin
            tick(1);
            c++;
        end
        chk(tag, 32'(xfer_pc.size() >= n), 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int c = 0;
        while (!o_valid && c < budget) begin
            tick(1);
            c++;
        end
        chk(tag, {31'd0, o_valid}, 32'd1);
    endtask

    function automatic logic [31:0] xp(input int i);
        return (i < xfer_pc.size()) ? xfer_pc[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] xi(input int i);
        return (i < xfer_instr.size()) ? xfer_instr[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] ra(input int i);
        return (i < req_addr.size()) ? req_addr[i] : 32'hDEAD_DEAD;
    endfunction

    initial begin
        logic req_seen;
        logic [31:0] held_pc;
        logic [31:0] held_instr;

        // Reset state
        tick(3);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_req", {31'd0, o_imem_req}, 32'd0);
        chk("rst_instr", o_instr, 32'h0000_0013);
        chk("rst_pc", o_pc, 32'h0000_0000);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("rst_misaligned", {31'd0, o_misaligned}, 32'd0);
`endif

        // Sequential fetch with immediate grant and 1-cycle memory
        clear_q();
        rst = 1'b0;
        wait_xfers("seq_count", 3, 30);
        chk("seq_pc0", xp(0), 32'h0000_0000);
        chk("seq_pc1", xp(1), 32'h0000_0004);
        chk("seq_pc2", xp(2), 32'h0000_0008);
        chk("seq_in0", xi(0), 32'hA5A5_0000);
        chk("seq_in1", xi(1), 32'hA5A5_0004);
        chk("seq_in2", xi(2), 32'hA5A5_0008);

        // Decode stall in HOLD
        i_ready = 1'b0;
        do_reset();
        wait_valid("stall_valid", 20);
        req_seen   = 1'b0;
        held_pc    = o_pc;
        held_instr = o_instr;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            req_seen = req_seen | o_imem_req;
        end
        chk("stall_req", {31'd0, req_seen}, 32'd0);
        chk("stall_pc", o_pc, 32'h0000_0000);
        chk("stall_instr", o_instr, 32'hA5A5_0000);
        chk("stall_pc_stable", o_pc, held_pc);
        chk("stall_instr_stable", o_instr, held_instr);
        chk("stall_still_valid", {31'd0, o_valid}, 32'd1);
        clear_q();
        i_ready = 1'b1;
        wait_xfers("stall_rel_count", 2, 20);
        chk("stall_rel_pc0", xp(0), 32'h0000_0000);
        chk("stall_rel_pc1", xp(1), 32'h0000_0004);
        chk("stall_rel_req", ra(0), 32'h0000_0004);

        // Redirect while waiting for a 2-cycle response
        lat = 2;
        do_reset();
        tick(1);
        chk("wait_req_low", {31'd0, o_imem_req}, 32'd0);
        i_jump_sel  = 1'b1;
        i_jump_addr = 32'h0000_0100;
        tick(1);
        i_jump_sel = 1'b0;
        wait_xfers("wait_jmp_count", 1, 20);
        chk("wait_jmp_pc", xp(0), 32'h0000_0100);
        chk("wait_jmp_instr", xi(0), 32'hA5A5_0100);
        chk("wait_jmp_req0", ra(0), 32'h0000_0000);
        chk("wait_jmp_req1", ra(1), 32'h0000_0100);

        // Redirect in HOLD with decode ready the same cycle
        lat     = 1;
        i_ready = 1'b0;
        do_reset();
        wait_valid("hold_valid", 20);
        clear_q();
        i_ready     = 1'b1;
        i_jump_sel  = 1'b1;
        i_jump_addr = 32'h0000_0200;
        tick(1);
        i_jump_sel = 1'b0;
        chk("hold_jmp_valid", {31'd0, o_valid}, 32'd0);
        wait_xfers("hold_jmp_count", 1, 20);
        chk("hold_jmp_pc", xp(0), 32'h0000_0200);
        chk("hold_jmp_req", ra(0), 32'h0000_0200);

        // Sequential wrap at the top of the address space
        i_imem_gnt = 1'b0;
        do_reset();
        i_jump_sel  = 1'b1;
        i_jump_addr = 32'hFFFF_FFFC;
        tick(1);
        i_jump_sel = 1'b0;
        chk("wrap_addr", o_imem_addr, 32'hFFFF_FFFC);
        chk("wrap_req", {31'd0, o_imem_req}, 32'd1);
        i_imem_gnt = 1'b1;
        wait_xfers("wrap_count", 2, 20);
        chk("wrap_pc0", xp(0), 32'hFFFF_FFFC);
        chk("wrap_pc1", xp(1), 32'h0000_0000);
        chk("wrap_req1", ra(1), 32'h0000_0000);

        // Misaligned redirect target
        i_imem_gnt = 1'b0;
        do_reset();
        i_jump_sel  = 1'b1;
        i_jump_addr = 32'h0000_0102;
        tick(1);
        i_jump_sel = 1'b0;
        i_imem_gnt = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
        req_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            req_seen = req_seen | o_imem_req;
        end
        chk("mis_flag", {31'd0, o_misaligned}, 32'd1);
        chk("mis_req", {31'd0, req_seen}, 32'd0);
        chk("mis_req_count", 32'(req_addr.size()), 32'd0);
`else
        chk("mis_addr", o_imem_addr, 32'h0000_0100);
        wait_xfers("mis_count", 1, 20);
        chk("mis_pc", xp(0), 32'h0000_0100);
        chk("mis_req", ra(0), 32'h0000_0100);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
